uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Hardware UART receiver with an integrated receive FIFO.
- Sits directly downstream of the virtual UART's transmit pin (uart_rx_i path inside sonata_system).
- Deserialises 8N1 frames from the serial line and presents bytes to the system bus through a ready/valid read port.
- Also used standalone in the Verilator bench to check bytes driven by the UART DPI model.

Parameters:
ClockFrequency, 50_000_000, system clock frequency in Hz.
BaudRate, 115_200, line rate in baud; bit period Div = round(ClockFrequency/BaudRate), which is 434 at defaults; Div must be >= 4.
FifoDepth, 8, receive FIFO entries; power of two, 2..64.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  synchronous reset, active-high.
rx_i  input  1  asynchronous serial line, idle high.
rdata_o  output  8  head-of-FIFO byte; valid when rvalid_o = 1.
rvalid_o  output  1  FIFO not empty.
rready_i  input  1  pop the head entry when rvalid_o & rready_i.
level_o  output  $clog2(FifoDepth+1)  current FIFO occupancy.
overflow_o  output  1  sticky: a byte was dropped because the FIFO was full.
frame_err_o  output  1  sticky: stop bit sampled low.
clear_err_i  input  1  clears both sticky flags.

Behaviour:
Reset:
- All state returns to IDLE; FIFO is emptied.
- rvalid_o = 0, rdata_o = 0, level_o = 0, overflow_o = 0, frame_err_o = 0.
- Both synchroniser flops are set to 1.
- Reset asserted mid-frame aborts the frame; no partial byte is pushed.

Input path:
- rx_i passes through a 2-flop synchroniser, giving rx_s.
- A falling-edge detector on rx_s uses one extra flop.

Receiver FSM (bit counter: Div-wide down-counter; bit index 0..7; shift register 8 bits):
- IDLE: on a falling edge of rx_s, load counter with Div/2 - 1 and go to START.
- START: when counter = 0, sample rx_s.
  - If rx_s = 1: false start, return to IDLE.
  - If rx_s = 0: load counter with Div - 1, bit index = 0, go to DATA.
- DATA: when counter = 0, shift rx_s into the MSB (LSB-first line order) and reload Div - 1.
  - After bit 7, go to STOP.
- STOP: when counter = 0, sample rx_s.
  - If 1: push the byte and go to IDLE.
  - If 0: set frame_err_o, discard the byte, go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. Break conditions therefore produce exactly one frame error.

FIFO:
- First-word-fall-through, circular buffer.
- Pointers are $clog2(FifoDepth) bits and wrap naturally.
- Occupancy counter is kept separately.
- Push latency: rvalid_o and rdata_o are updated in the cycle after the stop-bit sample cycle.
- Push when level = FifoDepth with no pop in the same cycle: byte dropped, overflow_o set, FIFO contents unchanged.
- Simultaneous push and pop when full: both take effect; level stays at FifoDepth; no overflow.
- Simultaneous push and pop when empty: the pop is ignored (rvalid_o was 0); level becomes 1.
- Pop when empty: ignored.
- rdata_o holds its last value while rvalid_o = 0; do not check it in that state.

Sticky flags:
- clear_err_i clears both flags.
- If a set event and clear_err_i occur in the same cycle, set wins.

Receiver and FIFO operate independently; a pop never stalls reception.

Test Plan:
Use ClockFrequency = 1_000_000 and BaudRate = 100_000 (Div = 10) and FifoDepth = 4 unless noted.
1. Drive byte 0xA5 as 8N1, then hold rready_i = 0 -> rvalid_o rises 1 cycle after the stop-bit sample, rdata_o = 0xA5, level_o = 1; pulse rready_i -> level_o = 0, rvalid_o = 0.
2. Send 5 bytes 0x01..0x05 with rready_i = 0 -> level_o = 4, overflow_o = 1; pops return 0x01..0x04 in order; assert clear_err_i -> overflow_o = 0.
3. Send a frame with the stop bit low (data 0x3C) -> frame_err_o = 1, level_o unchanged; hold the line low for 30 cycles, then send 0x55 -> exactly one error, 0x55 received.
4. Glitch rx_i low for 3 cycles -> false start detected, no push, FSM back in IDLE, next byte 0x7E received correctly.
5. With the FIFO full, pop in the same cycle the 5th byte pushes -> overflow_o stays 0, level_o = 4, later pops return bytes 2..5.
6. Assert rst_i during data bit 4 of 0xFF, release, then send 0x12 -> only 0x12 appears, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Sticky overflow / frame-error flags; set takes priority over clear.
module uart_rx_fifo #(
   parameter int unsigned ClockFrequency = 50_000_000,
   parameter int unsigned BaudRate       = 115_200,
   parameter int unsigned FifoDepth      = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             rx_i,
   output logic [7:0]                       rdata_o,
   output logic                             rvalid_o,
   input  logic                             rready_i,
   output logic [$clog2(FifoDepth+1)-1:0]   level_o,
   output logic                             overflow_o,
   output logic                             frame_err_o,
   input  logic                             clear_err_i
);

   localparam int unsigned Div  = (ClockFrequency + BaudRate / 2) / BaudRate;
   localparam int unsigned CntW = $clog2(Div);
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned LvlW = $clog2(FifoDepth + 1);

   localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(Div - 1);
   localparam logic [LvlW-1:0] LvlFull = LvlW'(FifoDepth);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e state_q, state_d;

   logic            rx_meta_q, rx_s_q, rx_prev_q;
   logic            fall;
   logic [CntW-1:0] cnt_q;
   logic            cnt_zero;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;

   logic cnt_load_half, cnt_load_full, bit_clr, shift_en, push, ferr_set;

   logic [7:0]      mem_q [FifoDepth];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [LvlW-1:0] level_q;
   logic            full, empty, pop, wr, ovf_set;
   logic            overflow_q, frame_err_q;

   // Synchroniser plus one flop for falling-edge detection; idle-high reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   assign fall     = rx_prev_q & ~rx_s_q;
   assign cnt_zero = (cnt_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (fall) state_d = StStart;
         StStart: if (cnt_zero) state_d = rx_s_q ? StIdle : StData;
         StData:  if (cnt_zero && bit_idx_q == 3'd7) state_d = StStop;
         StStop:  if (cnt_zero) state_d = rx_s_q ? StIdle : StBreak;
         StBreak: if (rx_s_q) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_load_half = (state_q == StIdle) && fall;
      cnt_load_full = ((state_q == StStart) && cnt_zero && !rx_s_q) ||
                      ((state_q == StData) && cnt_zero);
      bit_clr       = (state_q == StStart) && cnt_zero;
      shift_en      = (state_q == StData) && cnt_zero;
      push          = (state_q == StStop) && cnt_zero && rx_s_q;
      ferr_set      = (state_q == StStop) && cnt_zero && !rx_s_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         if (cnt_load_half) begin
            cnt_q <= CntHalf;
         end else if (cnt_load_full) begin
            cnt_q <= CntFull;
         end else if (!cnt_zero) begin
            cnt_q <= cnt_q - CntW'(1);
         end
         if (bit_clr) begin
            bit_idx_q <= '0;
         end else if (shift_en) begin
            bit_idx_q <= bit_idx_q + 3'd1;
         end
         // Line order is LSB first, so each new bit enters at the MSB.
         if (shift_en) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
         end
      end
   end

   assign full    = (level_q == LvlFull);
   assign empty   = (level_q == '0);
   assign pop     = rready_i && !empty;
   assign wr      = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         for (int i = 0; i < int'(FifoDepth); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr) begin
            mem_q[wptr_q] <= shift_q;
            wptr_q        <= wptr_q + PtrW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
         if (wr && !pop) begin
            level_q <= level_q + LvlW'(1);
         end else if (pop && !wr) begin
            level_q <= level_q - LvlW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (ovf_set) begin
            overflow_q <= 1'b1;
         end else if (clear_err_i) begin
            overflow_q <= 1'b0;
         end
         if (ferr_set) begin
            frame_err_q <= 1'b1;
         end else if (clear_err_i) begin
            frame_err_q <= 1'b0;
         end
      end
   end

   assign rdata_o     = mem_q[rptr_q];
   assign rvalid_o    = !empty;
   assign level_o     = level_q;
   assign overflow_o  = overflow_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomised bench for uart_rx_fifo; Div = 10, four-entry FIFO.
// Expectations come from a frame-level queue model of the receive path.
module tb_uart_rx_fifo;

   localparam int unsigned Cf    = 1_000_000;
   localparam int unsigned Br    = 100_000;
   localparam int unsigned Depth = 4;
   localparam int          Div   = 10;
   // Negedge (counted from the start-bit fall) at which a pushed byte is visible:
   // 2 sync flops + 1 edge cycle + half-bit wait + 9 full bits.
   localparam int          PushVis = 3 + Div / 2 + 9 * Div;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] rdata;
   logic       rvalid;
   logic       rready;
   logic [2:0] level;
   logic       overflow;
   logic       frame_err;
   logic       clear_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   bit         m_ovf;
   bit         m_ferr;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .ClockFrequency (Cf),
      .BaudRate       (Br),
      .FifoDepth      (Depth)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_i        (rx),
      .rdata_o     (rdata),
      .rvalid_o    (rvalid),
      .rready_i    (rready),
      .level_o     (level),
      .overflow_o  (overflow),
      .frame_err_o (frame_err),
      .clear_err_i (clear_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".level"}, 32'(level), 32'(mq.size()));
      check({tag, ".rvalid"}, 32'(rvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) check({tag, ".rdata"}, 32'(rdata), 32'(mq[0]));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
   endtask

   // One 100-cycle 8N1 frame starting at the next negedge; ends on negedge 99.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input bit pop_at_push, input bit check_lat);
      logic [9:0] bits;
      bit         popped;
      bits   = {stop_bit, b, 1'b0};
      popped = 1'b0;
      for (int k = 0; k < 10 * Div; k++) begin
         @(negedge clk);
         rx = bits[k / Div];
         if (k == PushVis - 1) begin
            if (check_lat) check("lat.before", 32'(rvalid), 32'(0));
            if (pop_at_push) begin
               if (mq.size() != 0) begin
                  check("pushpop.rdata", 32'(rdata), 32'(mq[0]));
                  popped = 1'b1;
               end
               rready = 1'b1;
            end
         end
         if (k == PushVis) begin
            rready = 1'b0;
            if (check_lat) begin
               check("lat.rvalid", 32'(rvalid), 32'(1));
               check("lat.rdata", 32'(rdata), 32'(b));
               check("lat.level", 32'(level), 32'(1));
            end
         end
      end
      if (popped) void'(mq.pop_front());
      if (stop_bit) begin
         if (mq.size() < Depth) mq.push_back(b);
         else m_ovf = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
      check_state("frame");
   endtask

   task automatic pop_one();
      @(negedge clk);
      if (mq.size() != 0) check("pop.rdata", 32'(rdata), 32'(mq[0]));
      check("pop.rvalid", 32'(rvalid), 32'(mq.size() != 0));
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
      check_state("pop");
   endtask

   task automatic clear_errs();
      @(negedge clk);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      check_state("clear");
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      bit         stop;
      bit         pp;
      rst       = 1'b1;
      rx        = 1'b1;
      rready    = 1'b0;
      clear_err = 1'b0;
      m_ovf     = 1'b0;
      m_ferr    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.rvalid", 32'(rvalid), 32'(0));
      check("rst.rdata", 32'(rdata), 32'(0));
      check("rst.level", 32'(level), 32'(0));
      check("rst.overflow", 32'(overflow), 32'(0));
      check("rst.frame_err", 32'(frame_err), 32'(0));
      rst = 1'b0;
      idle(5);

      // Single byte with exact push latency, then pop.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      pop_one();
      pop_one();  // empty pop is ignored

      // Overflow on the fifth byte, ordered drain, clear.
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pop_one();
      clear_errs();

      // Frame error followed by a held break: exactly one error.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      clear_errs();
      repeat (20) @(negedge clk);
      idle(5);
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      pop_one();

      // Three-cycle glitch is a false start.
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle(20);
      check_state("glitch");
      send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
      pop_one();

      // Push and pop in the same cycle while full.
      for (int i = 1; i <= 4; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
      send_frame(8'h25, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) pop_one();

      // Randomised traffic with occasional bad stop bits, same-cycle pops and clears.
      for (int n = 0; n < 14; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         pp   = ($urandom_range(0, 3) == 0);
         send_frame(b, stop, pp, 1'b0);
         idle(stop ? int'($urandom_range(0, 4)) : 6);
         for (int p = $urandom_range(0, 2); p > 0; p--) pop_one();
         if ($urandom_range(0, 4) == 0) clear_errs();
      end

      // Reset in the middle of data bit 4 of 0xFF with a byte already queued.
      send_frame(8'h9C, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rx = 1'b0;
      repeat (Div) @(negedge clk);
      rx = 1'b1;
      repeat (45) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst.rvalid", 32'(rvalid), 32'(0));
      check("midrst.rdata", 32'(rdata), 32'(0));
      check("midrst.level", 32'(level), 32'(0));
      check("midrst.overflow", 32'(overflow), 32'(0));
      check("midrst.frame_err", 32'(frame_err), 32'(0));
      rst = 1'b0;
      mq.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      idle(60);
      check_state("after_rst");
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      pop_one();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
